// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch engine with pause/resume, clear and overflow.
// Optional lap freeze is built in when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 500000,
    parameter int WRAP     = 1
) (
    input  logic                CLOCK_50,
    input  logic                RST,
    input  logic                start_stop_n,
    input  logic                lap_n,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                running,
    output logic                ovf,
    output logic                lap_hold,
    output logic                tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t state, state_nxt;

    logic [1:0] key_s1, key_s2, key_h;
    logic       start_ev, lap_ev;

    logic [PW-1:0]       pre, pre_nxt;
    logic [4*DIGITS-1:0] cnt, cnt_nxt, cnt_inc;
    logic                all9;
    logic                ovf_q, ovf_nxt;
    logic                tick_q, tick_nxt;

`ifdef STOPWATCH_LAP_EN
    logic                hold_q, hold_nxt;
    logic [4*DIGITS-1:0] lap_q, lap_nxt;
`endif

    // Two-flop key synchroniser plus history flop; press events are registered
    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            key_s1   <= 2'b11;
            key_s2   <= 2'b11;
            key_h    <= 2'b11;
            start_ev <= 1'b0;
            lap_ev   <= 1'b0;
        end else begin
            key_s1   <= {start_stop_n, lap_n};
            key_s2   <= key_s1;
            key_h    <= key_s2;
            start_ev <= ~key_s2[1] & key_h[1];
            lap_ev   <= ~key_s2[0] & key_h[0];
        end
    end

    // Decimal increment of the whole count with same-cycle carry chain
    always_comb begin
        cnt_inc = cnt;
        all9    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (all9) begin
                if (cnt[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    all9 = 1'b0;
                end
            end
        end
    end

    // Next state, prescaler, count, overflow and lap logic
    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_q;
        tick_nxt  = 1'b0;
`ifdef STOPWATCH_LAP_EN
        hold_nxt  = hold_q;
        lap_nxt   = lap_q;
`endif
        if (state == RUN) begin
            if (pre == PRE_MAX) begin
                pre_nxt  = '0;
                tick_nxt = 1'b1;
                if (all9) begin
                    ovf_nxt = 1'b1;
                    if (WRAP != 0) begin
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end else begin
                pre_nxt = pre + PW'(1);
            end
        end
        unique case (state)
            IDLE: begin
                if (start_ev) begin
                    state_nxt = RUN;
                    pre_nxt   = '0;
                end
            end
            RUN: begin
                if (start_ev) begin
                    state_nxt = STOP;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_ev && state_nxt == RUN) begin
                    hold_nxt = ~hold_q;
                    if (!hold_q) begin
                        lap_nxt = cnt_nxt;
                    end
                end
`endif
            end
            STOP: begin
                if (start_ev) begin
                    state_nxt = RUN;
                end else if (lap_ev) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    pre_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef STOPWATCH_LAP_EN
        if (state_nxt != RUN) begin
            hold_nxt = 1'b0;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            pre    <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            tick_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            hold_q <= 1'b0;
            lap_q  <= '0;
`endif
        end else begin
            state  <= state_nxt;
            pre    <= pre_nxt;
            cnt    <= cnt_nxt;
            ovf_q  <= ovf_nxt;
            tick_q <= tick_nxt;
`ifdef STOPWATCH_LAP_EN
            hold_q <= hold_nxt;
            lap_q  <= lap_nxt;
`endif
        end
    end

    assign running = (state == RUN);
    assign ovf     = ovf_q;
    assign tick    = tick_q;

`ifdef STOPWATCH_LAP_EN
    assign lap_hold = hold_q;
    assign bcd_out  = hold_q ? lap_q : cnt;
`else
    assign lap_hold = 1'b0;
    assign bcd_out  = cnt;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: checks two stopwatch instances (saturating and wrapping)
// against an arithmetic reference model every cycle plus directed scenarios.
module tb_stopwatch_core;

    localparam int TB_D   = 2;
    localparam int TB_DIV = 4;
    localparam int MAXV   = 10 ** TB_D;
    localparam int IDLE_S = 0;
    localparam int RUN_S  = 1;
    localparam int STOP_S = 2;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    typedef struct packed {
        int st;
        int pre;
        int cnt;
        int lapv;
        bit ovf;
        bit tick;
        bit hold;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] ss_n = 2'b11;
    logic [1:0] lp_n = 2'b11;

    logic [4*TB_D-1:0] bcd [2];
    logic run [2];
    logic ovf [2];
    logic hold [2];
    logic tck [2];

    mdl_t m [2];
    logic [4:0] hs [2];
    logic [4:0] hl [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // index 0: saturating instance, index 1: wrapping instance
    stopwatch_core #(.DIGITS(TB_D), .TICK_DIV(TB_DIV), .WRAP(0)) u_sat (
        .CLOCK_50(clk), .RST(rst_n),
        .start_stop_n(ss_n[0]), .lap_n(lp_n[0]),
        .bcd_out(bcd[0]), .running(run[0]), .ovf(ovf[0]),
        .lap_hold(hold[0]), .tick(tck[0])
    );

    stopwatch_core #(.DIGITS(TB_D), .TICK_DIV(TB_DIV), .WRAP(1)) u_wrap (
        .CLOCK_50(clk), .RST(rst_n),
        .start_stop_n(ss_n[1]), .lap_n(lp_n[1]),
        .bcd_out(bcd[1]), .running(run[1]), .ovf(ovf[1]),
        .lap_hold(hold[1]), .tick(tck[1])
    );

    function automatic logic [4*TB_D-1:0] to_bcd(int v);
        logic [4*TB_D-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < TB_D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic mdl_t step(mdl_t cur, bit s_ev, bit l_ev, bit wrap);
        mdl_t n;
        n = cur;
        n.tick = 1'b0;
        if (cur.st == RUN_S) begin
            if (cur.pre == TB_DIV - 1) begin
                n.pre = 0;
                n.tick = 1'b1;
                if (cur.cnt == MAXV - 1) begin
                    n.ovf = 1'b1;
                    if (wrap) n.cnt = 0;
                    else n.st = STOP_S;
                end else begin
                    n.cnt = cur.cnt + 1;
                end
            end else begin
                n.pre = cur.pre + 1;
            end
        end
        if (s_ev) begin
            if (cur.st == IDLE_S) begin
                n.st = RUN_S;
                n.pre = 0;
            end else if (cur.st == RUN_S) begin
                n.st = STOP_S;
            end else begin
                n.st = RUN_S;
            end
        end else if (l_ev) begin
            if (cur.st == STOP_S) begin
                n.st = IDLE_S;
                n.cnt = 0;
                n.pre = 0;
                n.ovf = 1'b0;
            end else if (LAP_EN && cur.st == RUN_S && n.st == RUN_S) begin
                n.hold = !cur.hold;
                if (!cur.hold) n.lapv = n.cnt;
            end
        end
        if (n.st != RUN_S) n.hold = 1'b0;
        return n;
    endfunction

    // Reference model: a key press falling before edge k acts at edge k+3
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m[i] <= '0;
                hs[i] <= '1;
                hl[i] <= '1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m[i] <= step(m[i], ~hs[i][2] & hs[i][3],
                             ~hl[i][2] & hl[i][3], i == 1);
                hs[i] <= {hs[i][3:0], ss_n[i]};
                hl[i] <= {hl[i][3:0], lp_n[i]};
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bcd%0d", i), 32'(bcd[i]),
                32'(to_bcd(m[i].hold ? m[i].lapv : m[i].cnt)));
            chk($sformatf("run%0d", i), 32'(run[i]), 32'(m[i].st == RUN_S));
            chk($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(m[i].ovf));
            chk($sformatf("hold%0d", i), 32'(hold[i]), 32'(m[i].hold));
            chk($sformatf("tick%0d", i), 32'(tck[i]), 32'(m[i].tick));
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            cmp_all();
        end
    endtask

    task automatic press(logic [1:0] sm, logic [1:0] lm);
        int h;
        h = $urandom_range(1, 3);
        ss_n = ~sm;
        lp_n = ~lm;
        cyc(h);
        ss_n = 2'b11;
        lp_n = 2'b11;
        cyc(1);
    endtask

    task automatic wait_run(int idx, logic lvl, string tag);
        for (int i = 0; i < 20 && run[idx] !== lvl; i++) cyc(1);
        chk(tag, 32'(run[idx]), 32'(lvl));
    endtask

    task automatic wait_cnt(int idx, int c, int p, string tag);
        for (int i = 0; i < 1000; i++) begin
            if (m[idx].cnt == c && m[idx].pre == p) break;
            cyc(1);
        end
        chk(tag, 32'(bcd[idx]), 32'(to_bcd(c)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset state
        cyc(3);
        for (int i = 0; i < 2; i++) begin
            chk("rst_bcd", 32'(bcd[i]), 32'h0);
            chk("rst_run", 32'(run[i]), 32'h0);
            chk("rst_ovf", 32'(ovf[i]), 32'h0);
            chk("rst_hold", 32'(hold[i]), 32'h0);
            chk("rst_tick", 32'(tck[i]), 32'h0);
        end
        rst_n = 1'b1;
        cyc(3);

        // basic count: 40 cycles after start gives 10 ticks
        press(2'b10, 2'b00);
        wait_run(1, 1'b1, "basic_start");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (tck[1]) n++;
        end
        chk("basic_ticks", 32'(n), 32'd10);
        chk("basic_bcd", 32'(bcd[1]), 32'h10);

        // pause at 23 with prescaler 2, hold, resume
        wait_cnt(1, 22, 2, "pause_pre");
        press(2'b10, 2'b00);
        wait_run(1, 1'b0, "pause_stop");
        chk("pause_bcd", 32'(bcd[1]), 32'h23);
        cyc(50);
        chk("pause_hold", 32'(bcd[1]), 32'h23);
        press(2'b10, 2'b00);
        wait_run(1, 1'b1, "resume_run");
        n = 0;
        while (n < 10 && !tck[1]) begin
            cyc(1);
            n++;
        end
        chk("resume_lat", 32'(n), 32'd2);
        chk("resume_bcd", 32'(bcd[1]), 32'h24);

        // stop then clear
        press(2'b10, 2'b00);
        wait_run(1, 1'b0, "clr_stop");
        press(2'b00, 2'b10);
        cyc(3);
        chk("clr_bcd", 32'(bcd[1]), 32'h0);
        chk("clr_ovf", 32'(ovf[1]), 32'h0);
        chk("clr_run", 32'(run[1]), 32'h0);

`ifdef STOPWATCH_LAP_EN
        press(2'b10, 2'b00);
        wait_run(1, 1'b1, "lap_start");
        wait_cnt(1, 14, 0, "lap_pre");
        press(2'b00, 2'b10);
        cyc(3);
        chk("lap_hold_on", 32'(hold[1]), 32'h1);
        chk("lap_frozen", 32'(bcd[1]), 32'h15);
        for (int i = 0; i < 200 && m[1].cnt < 32; i++) cyc(1);
        chk("lap_under", 32'(bcd[1]), 32'h15);
        press(2'b00, 2'b10);
        cyc(3);
        chk("lap_hold_off", 32'(hold[1]), 32'h0);
        chk("lap_live", 32'(bcd[1]), 32'(to_bcd(m[1].cnt)));
`else
        press(2'b10, 2'b00);
        wait_run(1, 1'b1, "nolap_start");
        cyc(8);
        press(2'b00, 2'b10);
        cyc(3);
        chk("nolap_hold", 32'(hold[1]), 32'h0);
        chk("nolap_run", 32'(run[1]), 32'h1);
`endif

        // start and lap together while running: stop only
        press(2'b10, 2'b10);
        cyc(3);
        chk("sim_run", 32'(run[1]), 32'h0);
        chk("sim_hold", 32'(hold[1]), 32'h0);
        press(2'b00, 2'b10);
        cyc(3);
        chk("sim_clr", 32'(bcd[1]), 32'h0);

        // overflow on both instances after 100 ticks
        press(2'b11, 2'b00);
        wait_run(1, 1'b1, "ovf_start1");
        chk("ovf_start0", 32'(run[0]), 32'h1);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (tck[1]) n++;
        end
        chk("ovf_ticks", 32'(n), 32'd100);
        chk("wrap_bcd", 32'(bcd[1]), 32'h00);
        chk("wrap_ovf", 32'(ovf[1]), 32'h1);
        chk("wrap_run", 32'(run[1]), 32'h1);
        chk("sat_bcd", 32'(bcd[0]), 32'h99);
        chk("sat_ovf", 32'(ovf[0]), 32'h1);
        chk("sat_run", 32'(run[0]), 32'h0);
        press(2'b10, 2'b00);
        wait_run(1, 1'b0, "ovf_stop");
        press(2'b00, 2'b11);
        cyc(3);
        chk("ovf_clr0", 32'(ovf[0]), 32'h0);
        chk("ovf_clr1", 32'(ovf[1]), 32'h0);

        // randomized key activity on both instances
        for (int k = 0; k < 60; k++) begin
            cyc($urandom_range(0, 10));
            press(2'($urandom), 2'($urandom));
        end
        press(2'b11, 2'b00);
        cyc(20);

        // asynchronous reset mid-count
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_bcd", 32'(bcd[i]), 32'h0);
            chk("arst_run", 32'(run[i]), 32'h0);
            chk("arst_ovf", 32'(ovf[i]), 32'h0);
            chk("arst_hold", 32'(hold[i]), 32'h0);
            chk("arst_tick", 32'(tck[i]), 32'h0);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised BCD stopwatch engine for the DE2 lab designs. It counts decimal digits at a tick rate divided down from CLOCK_50 and adds pause/resume, clear-while-stopped, an optional lap freeze, and overflow handling. It is fully synchronous: the count advances on a clock enable, not a gated clock. It sits between the push-button inputs and the `hex_7seg` decoders; the top level slices `bcd_out` per digit.

## Interface

- `DIGITS`, default 4: number of BCD digits; 1..8.
- `TICK_DIV`, default 500000: CLOCK_50 cycles per count tick (100 Hz, hundredths of a second); must be ≥2.
- `WRAP`, default 1: 1 = wrap to zero on overflow; 0 = saturate at all-9s and stop.

Ports:
- `CLOCK_50`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `start_stop_n`  in  1  raw active-low key (debounced externally); each press toggles run/stop.
- `lap_n`  in  1  raw active-low key; clears when stopped, toggles lap hold when running.
- `bcd_out`  out  4*DIGITS  displayed value; digit 0 in [3:0].
- `running`  out  1  high in RUN.
- `ovf`  out  1  sticky overflow flag.
- `lap_hold`  out  1  high while the display is frozen.
- `tick`  out  1  one-cycle pulse on each counted tick.

## Operation

- Key inputs are synchronised through 2 flops (reset value 1) plus a history flop. A press is the falling edge of the synchronised level and produces a single-cycle event.
- States:
  - IDLE: stopped, count zero.
  - RUN: counting.
  - STOP: paused, count held.
- Transitions:
  - IDLE --start--> RUN; prescaler cleared to 0.
  - RUN --start--> STOP; lap_hold cleared, display live.
  - STOP --start--> RUN; prescaler and count are retained, so the fractional tick is preserved.
  - STOP --lap--> IDLE; count, prescaler and ovf cleared.
  - IDLE --lap--> no effect.
  - RUN --lap--> toggles lap_hold.
- Prescaler counts 0..TICK_DIV-1 only in RUN. A tick fires in the cycle where prescaler == TICK_DIV-1, and the prescaler then returns to 0.
- On a tick, digit 0 increments. A digit at 9 rolls to 0 and carries into the next digit in the same cycle. There is no ripple clock between digits.
- Overflow occurs when all digits are 9 and a tick fires:
  - WRAP=1: count becomes all zero, ovf set, stays in RUN.
  - WRAP=0: count holds all 9s, ovf set, state forced to STOP.
  - ovf clears only on RST or on the STOP→IDLE clear.
- `bcd_out` shows the live count, or the lap register while lap_hold=1. The lap register loads the live count (post-increment value, if a tick fires in the same cycle) when lap_hold rises. The count keeps advancing underneath.
- Simultaneous start and lap events in the same cycle: start wins, lap is ignored.
- RST low at any time, including mid-count: all outputs go to 0 immediately and state goes to IDLE.

## Timing

- Reset values:
  - `bcd_out` = 0, `running` = 0, `ovf` = 0, `lap_hold` = 0, `tick` = 0.
  - State IDLE, prescaler 0, key sync flops 1.
- Key latency: a key falling before clock edge k registers as an event at edge k+2. `running`, `lap_hold` and `bcd_out` reflect it after edge k+3.
- `tick` is registered. The count update is visible in the same cycle `tick` is high, i.e. one edge after prescaler == TICK_DIV-1.
- From IDLE→RUN, the first tick arrives TICK_DIV cycles after `running` rises.

## Configuration

- `STOPWATCH_LAP_EN` defined: lap register and lap_hold behaviour included as above.
- Not defined:
  - no lap register; `lap_hold` tied 0; `bcd_out` always live.
  - `lap_n` in RUN is ignored; `lap_n` in STOP still clears to IDLE.

## Test plan

Parameters for all scenarios: DIGITS=2, TICK_DIV=4.

- Basic count: reset, press start → `running`=1; after 40 cycles from `running` rising, `bcd_out`=8'h10 with exactly 10 `tick` pulses.
- Overflow, WRAP=1: run 100 ticks → `bcd_out`=8'h00, `ovf`=1, `running`=1.
- Overflow, WRAP=0: run 100 ticks → `bcd_out`=8'h99, `ovf`=1, `running`=0.
- Pause/resume: stop at 8'h23 with prescaler=2, idle 50 cycles with no change, restart → next tick 2 cycles after `running` rises, `bcd_out`=8'h24.
- Lap and clear (LAP_EN):
  - lap at 8'h15 → `lap_hold`=1 and display held at 8'h15 while internal count passes 8'h31.
  - lap again → display live.
  - stop, then lap → `bcd_out`=0, `ovf`=0, IDLE.
- Edge cases:
  - start and lap pressed in the same cycle while RUN → STOP only, `lap_hold` unchanged (0).
  - RST asserted mid-count → all outputs 0 without waiting for a clock edge.
